// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the buffer read-side controller: widths, FSM encoding,
// and where SOP/EOP/channel live inside the header field.
package buffer_reader_pkg;

  localparam int DEF_DATA_WIDTH   = 40;
  localparam int DEF_HEADER_WIDTH = 8;
  localparam int DEF_TIMEOUT      = 15;
  localparam int DEF_CNT_WIDTH    = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD
  } state_t;

  // Channel id occupies the low header bits; SOP and EOP are the top two.
  localparam int CH_LSB = 0;

  function automatic int sop_pos(input int hw);
    return hw - 1;
  endfunction

  function automatic int eop_pos(input int hw);
    return hw - 2;
  endfunction

endpackage

// File: rtl/buffer_reader_if.sv
// Buffer pull port plus downstream valid/ready word stream.
// master = the reader, slave = buffer/consumer side.
interface buffer_reader_if
  import buffer_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int HEADER_WIDTH = DEF_HEADER_WIDTH
) ();

  logic [DATA_WIDTH-1:0]              buf_data;
  logic                               buf_empty;
  logic                               buf_next_ready;
  logic [DATA_WIDTH-HEADER_WIDTH-1:0] out_payload;
  logic [HEADER_WIDTH-3:0]            out_channel;
  logic                               out_sop;
  logic                               out_eop;
  logic                               out_valid;
  logic                               out_ready;

  modport master (
    input  buf_data, buf_empty, out_ready,
    output buf_next_ready, out_payload, out_channel, out_sop, out_eop, out_valid
  );

  modport slave (
    output buf_data, buf_empty, out_ready,
    input  buf_next_ready, out_payload, out_channel, out_sop, out_eop, out_valid
  );

endinterface

// File: rtl/buffer_reader_frame_check.sv
// Packet framing tracker: follows in-packet state across captured words and
// raises a sticky error on SOP inside a packet or a non-SOP word outside one.
module buffer_reader_frame_check (
  input  logic clk,
  input  logic reset,
  input  logic capture,
  input  logic sop,
  input  logic eop,
  input  logic err_clear,
  output logic frame_err
);

  logic in_pkt;
  logic bad;

  // Both illegal cases reduce to SOP matching the current in-packet state.
  assign bad = capture && (sop == in_pkt);

  // Track packet boundaries; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pkt    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (capture)
        in_pkt <= (sop | in_pkt) & ~eop;
      if (bad)
        frame_err <= 1'b1;
      else if (err_clear)
        frame_err <= 1'b0;
    end
  end

endmodule

// File: rtl/buffer_reader.sv
// Read-side controller for the shift-register buffer: pulls one word at a time,
// splits header from payload, holds it on a valid/ready port, counts traffic
// and flags buffers that never answer a request.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int HEADER_WIDTH = DEF_HEADER_WIDTH,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  buffer_reader_if.master      bus,
  input  logic                 err_clear,
  output logic                 frame_err,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam int PW      = DATA_WIDTH - HEADER_WIDTH;
  localparam int WW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SOP_BIT = sop_pos(HEADER_WIDTH);
  localparam int EOP_BIT = eop_pos(HEADER_WIDTH);

  state_t                  state;
  logic [WW-1:0]           wait_cnt;
  logic [HEADER_WIDTH-1:0] hdr;
  logic                    capture;

  assign hdr     = bus.buf_data[DATA_WIDTH-1 -: HEADER_WIDTH];
  // Only an all-zero word is a bubble; a bare header with zero payload is data.
  assign capture = (state == S_WAIT) && (bus.buf_data != '0);

  // Request/wait/hold sequencer with registered pull pulse, capture and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      wait_cnt           <= '0;
      bus.buf_next_ready <= 1'b0;
      bus.out_payload    <= '0;
      bus.out_channel    <= '0;
      bus.out_sop        <= 1'b0;
      bus.out_eop        <= 1'b0;
      bus.out_valid      <= 1'b0;
      timeout_err        <= 1'b0;
      word_count         <= '0;
      pkt_count          <= '0;
    end else begin
      // Pull request is high only while sitting in REQ.
      bus.buf_next_ready <= 1'b0;
      if (err_clear)
        timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.buf_empty) begin
            state              <= S_REQ;
            bus.buf_next_ready <= 1'b1;
          end
        end
        S_REQ: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // buf_empty is deliberately ignored here: the request is already out.
          if (capture) begin
            bus.out_payload <= bus.buf_data[PW-1:0];
            bus.out_channel <= hdr[CH_LSB +: HEADER_WIDTH-2];
            bus.out_sop     <= hdr[SOP_BIT];
            bus.out_eop     <= hdr[EOP_BIT];
            bus.out_valid   <= 1'b1;
            state           <= S_HOLD;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            word_count    <= word_count + 1'b1;
            if (bus.out_eop)
              pkt_count <= pkt_count + 1'b1;
            if (!bus.buf_empty) begin
              state              <= S_REQ;
              bus.buf_next_ready <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  buffer_reader_frame_check u_frame_check (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .sop       (hdr[SOP_BIT]),
    .eop       (hdr[EOP_BIT]),
    .err_clear (err_clear),
    .frame_err (frame_err)
  );

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: a queue-backed buffer model answers pull requests,
// expected words go into a scoreboard when pushed and are compared on transfer.
`timescale 1ns/1ps
module tb_buffer_reader;
  import buffer_reader_pkg::*;

  localparam int DW = 40;
  localparam int HW = 8;
  localparam int PW = DW - HW;
  localparam int TO = 15;
  localparam int CW = 4;

  typedef struct packed {
    logic [PW-1:0]   payload;
    logic [HW-3:0]   ch;
    logic            sop;
    logic            eop;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          err_clear = 1'b0;
  logic          frame_err, timeout_err;
  logic [CW-1:0] word_count, pkt_count;

  logic [DW-1:0] mem[$];
  exp_t          exp_q[$];
  bit            stall_nonempty = 1'b0;
  int            checks = 0;
  int            fails = 0;
  int            exp_wc = 0;
  int            exp_pc = 0;

  buffer_reader_if #(.DATA_WIDTH(DW), .HEADER_WIDTH(HW)) bus ();

  buffer_reader #(
    .DATA_WIDTH(DW), .HEADER_WIDTH(HW), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_clear   (err_clear),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .word_count  (word_count),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  // Buffer model: each pull shifts out the next stored word, or zero if none.
  always @(posedge clk or negedge reset) begin
    if (!reset) bus.buf_data <= '0;
    else if (bus.buf_next_ready) begin
      if (mem.size() > 0) bus.buf_data <= mem.pop_front();
      else                bus.buf_data <= '0;
    end
  end

  // Empty flag follows the model contents (stall_nonempty fakes a stuck buffer).
  always @(negedge clk) bus.buf_empty = (mem.size() == 0) && !stall_nonempty;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic sop, input logic eop, input logic [HW-3:0] ch,
                           input logic [PW-1:0] pl, input bit track);
    mem.push_back({sop, eop, ch, pl});
    if (track) begin
      exp_q.push_back({pl, ch, sop, eop});
      exp_wc++;
      if (eop) exp_pc++;
    end
  endtask

  // Scoreboard consumer: compares every transfer until all expected words are seen.
  task automatic service(input int max_cyc, input string tag);
    exp_t e, got;
    int   n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (bus.out_valid && bus.out_ready) begin
        e   = exp_q.pop_front();
        got = {bus.out_payload, bus.out_channel, bus.out_sop, bus.out_eop};
        checks++;
        if (got !== e) begin
          fails++;
          $display("FAIL %s_word: got %h required %h", tag, got, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.buf_next_ready, bus.out_sop, bus.out_eop, frame_err, timeout_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.out_valid, bus.buf_next_ready, bus.out_sop, bus.out_eop, frame_err, timeout_err});
    end
    checks++;
    if ({bus.out_payload, bus.out_channel, word_count, pkt_count} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h/%0d/%0d required all zero",
               bus.out_payload, bus.out_channel, word_count, pkt_count);
    end
    reset = 1'b1;
    exp_wc = 0;
    exp_pc = 0;
  endtask

  task automatic test_packet;
    bus.out_ready = 1'b1;
    push_word(1'b1, 1'b0, 6'd2, $urandom(), 1'b1);
    push_word(1'b0, 1'b0, 6'd2, 32'h0, 1'b1);
    push_word(1'b0, 1'b1, 6'd2, $urandom(), 1'b1);
    service(100, "pkt");
    checks++;
    if (word_count !== 4'd3) begin fails++; $display("FAIL pkt_wcount: got %0d required 3", word_count); end
    checks++;
    if (pkt_count !== 4'd1) begin fails++; $display("FAIL pkt_pcount: got %0d required 1", pkt_count); end
    checks++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL pkt_frame: got %b required 0", frame_err); end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    push_word(1'b1, 1'b1, 6'd5, 32'hA5A5_0001, 1'b1);
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin @(posedge clk); #1; end
    checks++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_capture: out_valid %b required 1", bus.out_valid); end
    stall_nonempty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.buf_next_ready, bus.out_payload} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
        fails++;
        $display("FAIL bp_hold: cycle %0d valid %b next_ready %b payload %h required 1 0 a5a50001",
                 i, bus.out_valid, bus.buf_next_ready, bus.out_payload);
      end
    end
    stall_nonempty = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    service(10, "bp");
    checks++;
    if (word_count !== CW'(exp_wc)) begin fails++; $display("FAIL bp_wcount: got %0d required %0d", word_count, CW'(exp_wc)); end
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: out_valid %b required 0", bus.out_valid); end
  endtask

  task automatic test_timeout;
    bus.out_ready = 1'b1;
    stall_nonempty = 1'b1;
    for (int i = 0; i < 10 && !bus.buf_next_ready; i++) begin @(posedge clk); #1; end
    checks++;
    if (bus.buf_next_ready !== 1'b1) begin fails++; $display("FAIL to_request: next_ready %b required 1", bus.buf_next_ready); end
    @(posedge clk); #1;
    repeat (TO - 1) begin @(posedge clk); #1; end
    checks++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_early: timeout_err %b required 0", timeout_err); end
    stall_nonempty = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag: timeout_err %b required 1", timeout_err); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.buf_next_ready !== 1'b0) begin fails++; $display("FAIL to_idle: next_ready %b required 0", bus.buf_next_ready); end
    end
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clear: timeout_err %b required 0", timeout_err); end
  endtask

  task automatic test_frame;
    bus.out_ready = 1'b1;
    push_word(1'b1, 1'b0, 6'd3, $urandom(), 1'b1);
    service(20, "frm1");
    checks++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL frm_first: frame_err %b required 0", frame_err); end
    push_word(1'b1, 1'b0, 6'd3, $urandom(), 1'b1);
    service(20, "frm2");
    checks++;
    if (frame_err !== 1'b1) begin fails++; $display("FAIL frm_second: frame_err %b required 1", frame_err); end
    checks++;
    if (word_count !== CW'(exp_wc)) begin fails++; $display("FAIL frm_wcount: got %0d required %0d", word_count, CW'(exp_wc)); end
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL frm_clear: frame_err %b required 0", frame_err); end
  endtask

  task automatic test_async_reset;
    bus.out_ready = 1'b0;
    push_word(1'b1, 1'b1, 6'd7, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin @(posedge clk); #1; end
    checks++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rst_capture: out_valid %b required 1", bus.out_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.buf_next_ready, bus.out_sop, bus.out_eop, bus.out_payload, bus.out_channel,
         word_count, pkt_count} !== '0) begin
      fails++;
      $display("FAIL rst_async: valid %b payload %h words %0d required all zero",
               bus.out_valid, bus.out_payload, word_count);
    end
    mem.delete();
    exp_wc = 0;
    exp_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.buf_next_ready !== 1'b0) begin fails++; $display("FAIL rst_norequest: next_ready %b required 0", bus.buf_next_ready); end
    end
    bus.out_ready = 1'b1;
    push_word(1'b1, 1'b1, 6'd1, $urandom(), 1'b1);
    service(20, "rst");
    checks++;
    if ({word_count, pkt_count} !== {4'd1, 4'd1}) begin
      fails++;
      $display("FAIL rst_counts: got %0d/%0d required 1/1", word_count, pkt_count);
    end
  endtask

  task automatic test_wrap;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_wc = 0;
    exp_pc = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(1'b1, 1'b1, 6'(i), $urandom(), 1'b1);
    service(300, "wrap");
    checks++;
    if (word_count !== 4'd1) begin fails++; $display("FAIL wrap_wcount: got %0d required 1", word_count); end
    checks++;
    if (pkt_count !== 4'd1) begin fails++; $display("FAIL wrap_pcount: got %0d required 1", pkt_count); end
    checks++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL wrap_frame: frame_err %b required 0", frame_err); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_packet();
    test_backpressure();
    test_timeout();
    test_frame();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
